// File: rtl/m_lsu.sv
// m_lsu: multi-cycle M-stage load/store unit.
// Req/ack data bus, sub-word and two-beat unaligned accesses, map checks.
module m_lsu #(
  parameter logic [31:0] DM_END    = 32'h0000_2fff,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7f10,
  parameter logic [31:0] DEV2_BASE = 32'h0000_7f20,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        err_adel,
  output logic        err_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_W  = 3'd1;
  localparam logic [2:0] OP_H  = 3'd2;
  localparam logic [2:0] OP_HU = 3'd3;
  localparam logic [2:0] OP_B  = 3'd4;
  localparam logic [2:0] OP_BU = 3'd5;
  localparam logic [2:0] OP_UW = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           err_q, err_d;
  logic           kill_q, kill_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    beat0_q, beat0_d;
  logic [31:0]    rdat_q, rdat_d;

  function automatic logic in_win(
    input logic [31:0] a,
    input logic [31:0] base,
    input logic [31:0] len
  );
    return (a >= base) && ((a - base) < len);
  endfunction

  // Windows are word aligned, so checking the first and last touched
  // byte covers every byte of an access spanning at most two words.
  function automatic logic byte_bad(
    input logic [31:0] a,
    input logic        sub,
    input logic        we
  );
    logic d01;
    logic d2;
    logic ro;
    d01 = in_win(a, DEV0_BASE, 32'd12) | in_win(a, DEV1_BASE, 32'd12);
    d2  = in_win(a, DEV2_BASE, 32'd4);
    ro  = in_win(a, DEV0_BASE + 32'd8, 32'd4)
        | in_win(a, DEV1_BASE + 32'd8, 32'd4);
    return !((a <= DM_END) | d01 | d2)
         | (sub & (d01 | d2))
         | (we & ro);
  endfunction

  logic        acc;
  logic        acc_err;
  logic        mis;
  logic [1:0]  last_off;
  logic [31:0] a_hi;

  assign acc = req_valid & (req_op != 3'd0) & (req_op != 3'd7) & ~flush;
  assign a_hi = req_addr + {30'd0, last_off};

  // Access extent and alignment of the incoming request.
  always_comb begin
    last_off = 2'd0;
    mis      = 1'b0;
    unique case (1'b1)
      req_op == OP_W: begin
        last_off = 2'd3;
        mis      = |req_addr[1:0];
      end
      req_op == OP_H,
      req_op == OP_HU: begin
        last_off = 2'd1;
        mis      = req_addr[0];
      end
      req_op == OP_UW: last_off = 2'd3;
      default: ;
    endcase
  end

  assign acc_err = mis
    | byte_bad(req_addr, req_op != OP_W, req_write)
    | byte_bad(a_hi, req_op != OP_W, req_write);

  logic [1:0]  k;
  logic        two;
  logic [4:0]  sh0;
  logic [5:0]  sh1;
  logic [31:0] word0;
  logic [3:0]  be0, be1;
  logic [31:0] wd0, wd1;
  logic [31:0] lane;
  logic [31:0] load_res;

  assign k     = addr_q[1:0];
  assign two   = (op_q == OP_UW) & (k != 2'd0);
  assign sh0   = {k, 3'b000};
  assign sh1   = 6'd32 - {1'b0, sh0};
  assign word0 = {addr_q[31:2], 2'b00};
  assign wd0   = wdata_q << sh0;
  assign wd1   = wdata_q >> sh1;
  assign be1   = 4'hf >> (3'd4 - {1'b0, k});
  assign lane  = bus_rdata >> sh0;

  // Lane strobes for the first beat and extension/merge of load data.
  always_comb begin
    be0      = 4'h0;
    load_res = bus_rdata;
    unique case (1'b1)
      op_q == OP_W,
      op_q == OP_UW: be0 = 4'hf << k;
      op_q == OP_H,
      op_q == OP_HU: be0 = 4'h3 << k;
      op_q == OP_B,
      op_q == OP_BU: be0 = 4'h1 << k;
      default: ;
    endcase
    unique case (1'b1)
      op_q == OP_H:  load_res = {{16{lane[15]}}, lane[15:0]};
      op_q == OP_HU: load_res = {16'd0, lane[15:0]};
      op_q == OP_B:  load_res = {{24{lane[7]}}, lane[7:0]};
      op_q == OP_BU: load_res = {24'd0, lane[7:0]};
      op_q == OP_UW: begin
        if (two) load_res = (beat0_q >> sh0) | (bus_rdata << sh1);
      end
      default: ;
    endcase
  end

  // Next-state, handshake and pulse outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    kill_d     = kill_q;
    cnt_d      = cnt_q;
    beat0_d    = beat0_q;
    rdat_d     = rdat_q;
    stall      = 1'b0;
    rd_valid   = 1'b0;
    err_adel   = 1'b0;
    err_ades   = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = 32'd0;
    bus_byteen = 4'd0;
    bus_wdata  = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          stall   = 1'b1;
          op_d    = req_op;
          we_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = acc_err;
          kill_d  = 1'b0;
          cnt_d   = '0;
          state_d = acc_err ? RESP : BEAT0;
        end
      end
      BEAT0, BEAT1: begin
        stall    = 1'b1;
        bus_req  = 1'b1;
        bus_we   = we_q;
        bus_addr = (state_q == BEAT1) ? word0 + 32'd4 : word0;
        if (we_q) begin
          bus_byteen = (state_q == BEAT1) ? be1 : be0;
          bus_wdata  = (state_q == BEAT1) ? wd1 : wd0;
        end
        // A store in its second beat must finish atomically.
        if (state_q == BEAT0 || !we_q) kill_d = kill_q | flush;
        if (bus_ack) begin
          cnt_d = '0;
          if (state_q == BEAT0) beat0_d = bus_rdata;
          if (kill_d) begin
            state_d = IDLE;
          end else if (state_q == BEAT0 && two) begin
            state_d = BEAT1;
          end else begin
            state_d = RESP;
            if (!we_q) rdat_d = load_res;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = kill_d ? IDLE : RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!flush) begin
          rd_valid = ~err_q;
          err_adel = err_q & ~we_q;
          err_ades = err_q & we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_data = rdat_q;

  // State and request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
      beat0_q <= 32'd0;
      rdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      beat0_q <= beat0_d;
      rdat_q  <= rdat_d;
    end
  end

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: directed and random checks of m_lsu
// against a byte-level memory and access-rule model.
module tb_m_lsu;

  localparam logic [31:0] DM_END = 32'h0000_2fff;
  localparam logic [31:0] DEV0   = 32'h0000_7f00;
  localparam logic [31:0] DEV1   = 32'h0000_7f10;
  localparam logic [31:0] DEV2   = 32'h0000_7f20;

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_ADEL  = 2;
  localparam int K_ADES  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err_adel;
  logic        err_ades;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  m_lsu dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .rd_valid(rd_valid),
    .rd_data(rd_data), .err_adel(err_adel),
    .err_ades(err_ades), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:32767];

  int          o_kind, o_npulse, o_pcyc, o_nstall;
  int          o_nreq, o_nbeats;
  bit          o_unstable, o_hang;
  logic [31:0] o_rd;
  logic [31:0] o_baddr [2];
  logic [3:0]  o_ben [2];
  logic [31:0] o_bwd [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd1, 3'd6: return 4;
      3'd2, 3'd3: return 2;
      3'd4, 3'd5: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic bit in_win(input logic [31:0] b,
                                input logic [31:0] base,
                                input int len);
    return (b >= base) && (b < base + len);
  endfunction

  function automatic bit ref_err(input bit w, input logic [2:0] op,
                                 input logic [31:0] a);
    bit e;
    bit dev;
    logic [31:0] b;
    e = 0;
    if (op == 3'd1 && (a % 4) != 0) e = 1;
    if ((op == 3'd2 || op == 3'd3) && (a % 2) != 0) e = 1;
    for (int i = 0; i < op_size(op); i++) begin
      b = a + i;
      dev = in_win(b, DEV0, 12) || in_win(b, DEV1, 12)
         || in_win(b, DEV2, 4);
      if (!(b <= DM_END || dev)) e = 1;
      if (dev && op != 3'd1) e = 1;
      if (w && (in_win(b, DEV0 + 8, 4) || in_win(b, DEV1 + 8, 4)))
        e = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op,
                                           input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] b;
    v = 0;
    for (int i = 0; i < op_size(op); i++) begin
      b = a + i;
      v = v | (32'(mem[b[14:0]]) << (8 * i));
    end
    if (op == 3'd2 && v[15]) v = v | 32'hffff_0000;
    if (op == 3'd4 && v[7]) v = v | 32'hffff_ff00;
    return v;
  endfunction

  // Issues one request and plays the bus slave cycle by cycle.
  // lat < 0 means the beat is never acknowledged.
  task automatic run(input bit w, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int lat0, input int lat1, input int fl);
    int c;
    int wait_c;
    int lat;
    bit in_beat;
    logic [14:0] ix;
    o_kind = K_NONE; o_npulse = 0; o_pcyc = -1; o_nstall = 0;
    o_nreq = 0; o_nbeats = 0; o_unstable = 0; o_hang = 0;
    o_rd = 0;
    o_baddr = '{0, 0}; o_ben = '{0, 0}; o_bwd = '{0, 0};
    wait_c = 0;
    in_beat = 0;
    @(negedge clk);
    req_valid = 1; req_write = w; req_op = op;
    req_addr = a; req_wdata = wd; flush = (fl == 0);
    #1;
    if (stall) o_nstall++;
    c = 1;
    while (c < 200) begin
      @(negedge clk);
      req_valid = 0; bus_ack = 0; flush = (fl == c);
      #1;
      if (stall) o_nstall++;
      if (rd_valid) begin
        o_npulse++; o_kind = K_VALID; o_pcyc = c; o_rd = rd_data;
      end
      if (err_adel) begin o_npulse++; o_kind = K_ADEL; o_pcyc = c; end
      if (err_ades) begin o_npulse++; o_kind = K_ADES; o_pcyc = c; end
      if (bus_req) begin
        o_nreq++;
        if (!in_beat) begin
          in_beat = 1;
          wait_c = 0;
          if (o_nbeats < 2) begin
            o_baddr[o_nbeats] = bus_addr;
            o_ben[o_nbeats] = bus_byteen;
            o_bwd[o_nbeats] = bus_wdata;
          end
        end else if (o_nbeats < 2) begin
          if (bus_addr !== o_baddr[o_nbeats]
              || bus_byteen !== o_ben[o_nbeats]
              || bus_wdata !== o_bwd[o_nbeats]
              || bus_we !== w)
            o_unstable = 1;
        end
        lat = (o_nbeats == 0) ? lat0 : lat1;
        if (lat >= 0 && wait_c == lat) begin
          bus_ack = 1;
          ix = bus_addr[14:0];
          bus_rdata = {mem[ix + 15'd3], mem[ix + 15'd2],
                       mem[ix + 15'd1], mem[ix]};
          if (bus_we)
            for (int l = 0; l < 4; l++)
              if (bus_byteen[l])
                mem[ix + 15'(l)] = bus_wdata[8 * l +: 8];
          in_beat = 0;
          o_nbeats++;
        end else begin
          wait_c++;
        end
      end
      if (!bus_req && !stall && !(rd_valid || err_adel || err_ades))
        break;
      c++;
    end
    if (c >= 200) o_hang = 1;
    bus_ack = 0;
    flush = 0;
  endtask

  // Runs one request and checks it against the model.
  task automatic check_op(input string tag, input bit w,
                          input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input int lat0,
                          input int lat1, input int fl);
    bit e;
    int nb;
    int ereq;
    logic [31:0] base;
    logic [31:0] b;
    logic [31:0] ev;
    logic [7:0] emem [8];
    logic [3:0] eben [2];
    e = ref_err(w, op, a);
    base = {a[31:2], 2'b00};
    for (int j = 0; j < 8; j++) begin
      b = base + j;
      emem[j] = mem[b[14:0]];
    end
    ev = ref_load(op, a);
    eben = '{0, 0};
    if (!e && w)
      for (int i = 0; i < op_size(op); i++) begin
        b = a + i;
        if (b[31:2] == base[31:2]) eben[0][b[1:0]] = 1;
        else eben[1][b[1:0]] = 1;
        emem[b - base] = wd[8 * i +: 8];
      end
    nb = (op == 3'd6 && a[1:0] != 0) ? 2 : 1;
    ereq = lat0 + 1 + ((nb == 2) ? lat1 + 1 : 0);
    run(w, op, a, wd, lat0, lat1, fl);
    chk({tag, ".hang"}, 32'(o_hang), 0);
    chk({tag, ".npulse"}, o_npulse, 1);
    if (e) begin
      chk({tag, ".kind"}, o_kind, w ? K_ADES : K_ADEL);
      chk({tag, ".pcyc"}, o_pcyc, 1);
      chk({tag, ".nreq"}, o_nreq, 0);
    end else begin
      chk({tag, ".kind"}, o_kind, K_VALID);
      chk({tag, ".nbeats"}, o_nbeats, nb);
      chk({tag, ".nreq"}, o_nreq, ereq);
      chk({tag, ".pcyc"}, o_pcyc, ereq + 1);
      chk({tag, ".nstall"}, o_nstall, ereq + 1);
      chk({tag, ".addr0"}, o_baddr[0], base);
      chk({tag, ".ben0"}, 32'(o_ben[0]), w ? 32'(eben[0]) : 0);
      if (nb == 2) begin
        chk({tag, ".addr1"}, o_baddr[1], base + 4);
        chk({tag, ".ben1"}, 32'(o_ben[1]), w ? 32'(eben[1]) : 0);
      end
      if (!w) chk({tag, ".rd"}, o_rd, ev);
      chk({tag, ".stable"}, 32'(o_unstable), 0);
    end
    for (int j = 0; j < 8; j++) begin
      b = base + j;
      chk($sformatf("%s.mem%0d", tag, j), 32'(mem[b[14:0]]),
          32'(emem[j]));
    end
  endtask

  initial begin : main
    logic [31:0] a;
    logic [2:0]  op;
    bit          w;
    int          r;
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    reset_n = 0; req_valid = 0; req_write = 0; req_op = 0;
    req_addr = 0; req_wdata = 0; flush = 0;
    bus_ack = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 32'(stall), 0);
    chk("rst.rdv", 32'(rd_valid), 0);
    chk("rst.err", {30'd0, err_adel, err_ades}, 0);
    chk("rst.req", 32'(bus_req), 0);
    chk("rst.addr", bus_addr, 0);
    chk("rst.rd", rd_data, 0);
    reset_n = 1;

    // lb / lbu with sign and zero extension
    {mem[3], mem[2], mem[1], mem[0]} = 32'h80ff_1234;
    check_op("lb", 0, 3'd4, 32'h3, 0, 0, 0, -1);
    chk("lb.lit", o_rd, 32'hffff_ff80);
    chk("lb.stall2", o_nstall, 2);
    check_op("lbu", 0, 3'd5, 32'h3, 0, 0, 0, -1);
    chk("lbu.lit", o_rd, 32'h0000_0080);

    // sh upper half
    check_op("sh", 1, 3'd2, 32'h102, 32'h1234_abcd, 0, 0, -1);
    chk("sh.addr", o_baddr[0], 32'h100);
    chk("sh.ben", 32'(o_ben[0]), 32'hc);
    chk("sh.wd", 32'(o_bwd[0][31:16]), 32'habcd);

    // unaligned word load
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'(8'h11 * (i + 1));
    check_op("ulw", 0, 3'd6, 32'h11, 0, 0, 0, -1);
    chk("ulw.lit", o_rd, 32'h5544_3322);

    // address errors
    check_op("sw_ro", 1, 3'd1, 32'h7f08, 32'h1, 0, 0, -1);
    check_op("lh_mis", 0, 3'd2, 32'h1, 0, 0, 0, -1);
    check_op("lw_oom", 0, 3'd1, 32'h3000, 0, 0, 0, -1);
    check_op("ulw_end", 0, 3'd6, DM_END - 1, 0, 0, 0, -1);
    check_op("lw_dev", 0, 3'd1, 32'h7f04, 0, 1, 0, -1);
    check_op("lb_dev", 0, 3'd4, 32'h7f20, 0, 0, 0, -1);
    check_op("sw_dev2", 1, 3'd1, 32'h7f20, 32'hcafe_f00d, 2, 0, -1);

    // bus timeout
    run(0, 3'd1, 32'h40, 0, -1, 0, -1);
    chk("to_ld.nreq", o_nreq, 16);
    chk("to_ld.kind", o_kind, K_ADEL);
    chk("to_ld.npulse", o_npulse, 1);
    run(1, 3'd1, 32'h44, 32'h5, -1, 0, -1);
    chk("to_st.nreq", o_nreq, 16);
    chk("to_st.kind", o_kind, K_ADES);

    // flush cases
    check_op("usw_fl", 1, 3'd6, 32'h2, 32'hdead_beef, 0, 0, 2);
    run(0, 3'd1, 32'h20, 0, 3, 0, 1);
    chk("fl_b0.npulse", o_npulse, 0);
    chk("fl_b0.nreq", o_nreq, 4);
    chk("fl_b0.nstall", o_nstall, 5);
    chk("fl_b0.hang", 32'(o_hang), 0);
    run(0, 3'd6, 32'h21, 0, 0, 1, 2);
    chk("fl_b1ld.npulse", o_npulse, 0);
    chk("fl_b1ld.nbeats", o_nbeats, 2);
    run(0, 3'd4, 32'h0, 0, 0, 0, 2);
    chk("fl_resp.npulse", o_npulse, 0);
    chk("fl_resp.nreq", o_nreq, 1);
    run(0, 3'd1, 32'h0, 0, 0, 0, 0);
    chk("fl_idle.nstall", o_nstall, 0);
    chk("fl_idle.nreq", o_nreq, 0);
    run(0, 3'd7, 32'h0, 0, 0, 0, -1);
    chk("op7.nstall", o_nstall, 0);
    chk("op7.npulse", o_npulse, 0);

    // reset in the middle of a beat
    @(negedge clk);
    req_valid = 1; req_write = 0; req_op = 3'd1; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 0;
    #1;
    chk("rstmid.req_before", 32'(bus_req), 1);
    reset_n = 0;
    #1;
    chk("rstmid.req", 32'(bus_req), 0);
    chk("rstmid.stall", 32'(stall), 0);
    @(negedge clk);
    reset_n = 1;

    // random traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) a = $urandom_range(0, 32'h2fff);
      else if (r == 6) a = $urandom_range(32'h2ff8, 32'h3003);
      else if (r == 7)
        a = ($urandom_range(0, 1) ? DEV1 : DEV0) + $urandom_range(0, 15);
      else if (r == 8) a = DEV2 + $urandom_range(0, 7);
      else a = $urandom;
      op = 3'($urandom_range(1, 6));
      w = 1'($urandom_range(0, 1));
      check_op($sformatf("rnd%0d", n), w, op, a, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
